// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Optional macro RST_SEQ_ACK_EN (see reset_sequencer.sv) adds per-stage acknowledge gating.
package reset_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_RELEASE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Default parameter values.
  localparam int RST_SEQ_N_STAGES       = 4;
  localparam int RST_SEQ_ASSERT_CYCLES  = 16;
  localparam int RST_SEQ_STAGE_GAP      = 8;
  localparam int RST_SEQ_TIMEOUT_CYCLES = 1024;

  // Width of the shared phase counter: large enough to hold the longest
  // phase length plus one, so it saturates rather than wrapping.
  function automatic int cnt_width(input int assert_cycles, input int stage_gap,
                                   input int timeout_cycles);
    int m;
    m = assert_cycles;
    if (stage_gap > m) m = stage_gap;
    if (timeout_cycles > m) m = timeout_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count compare.
// One instance is reused for the assert, stage-gap and ack-timeout phases;
// the owner selects the terminal count for the current phase.
module reset_seq_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_tc,
  output logic         o_hit
);

  logic [W-1:0] count;

  // Count enabled edges; clear has priority; hold at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      count <= '0;
    end else if (i_en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Terminal count reached (or passed, which can only happen at saturation).
  assign o_hit = (count >= i_tc);

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: all stage resets assert together on i_rst/i_sw_rst and
// release one at a time in index order; o_done flags the end of the sequence.
// Optional macro RST_SEQ_ACK_EN: adds i_ack/o_err; each following stage
// waits for the previous stage's acknowledge (or a timeout, which sets o_err).
// o_dbg_state exposes the FSM state for observation.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_STAGES       = RST_SEQ_N_STAGES,
  parameter int ASSERT_CYCLES  = RST_SEQ_ASSERT_CYCLES,
  parameter int STAGE_GAP      = RST_SEQ_STAGE_GAP,
  parameter int TIMEOUT_CYCLES = RST_SEQ_TIMEOUT_CYCLES
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sw_rst,
  output logic [N_STAGES-1:0] o_rst,
  output state_t              o_dbg_state,
`ifdef RST_SEQ_ACK_EN
  input  logic [N_STAGES-1:0] i_ack,
  output logic                o_err,
`endif
  output logic                o_done
);

  localparam int CW = cnt_width(ASSERT_CYCLES, STAGE_GAP, TIMEOUT_CYCLES);
  localparam int KW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [CW-1:0] ASSERT_TC = CW'(ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_TC    = CW'(STAGE_GAP - 1);
  localparam logic [KW-1:0] LAST_K    = KW'(N_STAGES - 1);
`ifdef RST_SEQ_ACK_EN
  localparam logic [CW-1:0] TIMEOUT_TC = CW'(TIMEOUT_CYCLES - 1);
`endif

  logic                rst_any;
  state_t              state, state_nx;
  logic [KW-1:0]       k, k_nx;          // index of the next stage to release
  logic [N_STAGES-1:0] rst_nx;
  logic                done_nx;
  logic                tmr_clr, tmr_en, tmr_hit;
  logic [CW-1:0]       tmr_tc;
`ifdef RST_SEQ_ACK_EN
  logic                last_wait, last_wait_nx;  // all released, waiting for last ack
  logic                gap_done, gap_done_nx;    // gap elapsed, now timing the ack
  logic                err_set;
  logic [KW-1:0]       prev_k;
`endif

  assign rst_any     = i_rst | i_sw_rst;
  assign o_dbg_state = state;

  reset_seq_timer #(.W(CW)) u_timer (
    .i_clk (i_clk),
    .i_clr (tmr_clr),
    .i_en  (tmr_en),
    .i_tc  (tmr_tc),
    .o_hit (tmr_hit)
  );

  // Next-state, next-output and timer control for the release sequence.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    rst_nx   = o_rst;
    done_nx  = o_done;
    tmr_clr  = rst_any;
    tmr_en   = 1'b0;
    tmr_tc   = ASSERT_TC;
`ifdef RST_SEQ_ACK_EN
    last_wait_nx = last_wait;
    gap_done_nx  = gap_done;
    err_set      = 1'b0;
    prev_k       = k - 1'b1;
`endif
    case (state)
      S_ASSERT: begin
        tmr_tc = ASSERT_TC;
        if (tmr_hit) begin
          rst_nx[0] = 1'b0;
          tmr_clr   = 1'b1;
          if (N_STAGES == 1) begin
`ifdef RST_SEQ_ACK_EN
            state_nx     = S_RELEASE;
            last_wait_nx = 1'b1;
`else
            state_nx = S_DONE;
            done_nx  = 1'b1;
`endif
          end else begin
            state_nx = S_RELEASE;
            k_nx     = KW'(1);
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_RELEASE: begin
`ifdef RST_SEQ_ACK_EN
        if (last_wait) begin
          tmr_tc = TIMEOUT_TC;
          if (i_ack[LAST_K]) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end else if (tmr_hit) begin
            err_set  = 1'b1;
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end else begin
          tmr_tc = gap_done ? TIMEOUT_TC : GAP_TC;
          if (tmr_hit || gap_done) begin
            // Gap has elapsed: release on ack, or on timeout without one.
            if (i_ack[prev_k] || (tmr_hit && (gap_done || (GAP_TC == TIMEOUT_TC)))) begin
              err_set     = ~i_ack[prev_k];
              rst_nx[k]   = 1'b0;
              tmr_clr     = 1'b1;
              gap_done_nx = 1'b0;
              if (k == LAST_K) last_wait_nx = 1'b1;
              else             k_nx = k + 1'b1;
            end else begin
              gap_done_nx = 1'b1;
              tmr_en      = 1'b1;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
`else
        tmr_tc = GAP_TC;
        if (tmr_hit) begin
          rst_nx[k] = 1'b0;
          tmr_clr   = 1'b1;
          if (k == LAST_K) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end else begin
            k_nx = k + 1'b1;
          end
        end else begin
          tmr_en = 1'b1;
        end
`endif
      end
      S_DONE: begin
        rst_nx  = '0;
        done_nx = 1'b1;
      end
      default: begin
        state_nx = S_ASSERT;
      end
    endcase
  end

  // State and output registers; any reset source restarts the whole sequence.
  always_ff @(posedge i_clk) begin
    if (rst_any) begin
      state  <= S_ASSERT;
      k      <= '0;
      o_rst  <= '1;
      o_done <= 1'b0;
`ifdef RST_SEQ_ACK_EN
      last_wait <= 1'b0;
      gap_done  <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      k      <= k_nx;
      o_rst  <= rst_nx;
      o_done <= done_nx;
`ifdef RST_SEQ_ACK_EN
      last_wait <= last_wait_nx;
      gap_done  <= gap_done_nx;
`endif
    end
  end

`ifdef RST_SEQ_ACK_EN
  // Sticky timeout flag: survives software reset, cleared only by i_rst.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if (err_set && !i_sw_rst) begin
      o_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer (N_STAGES=3, ASSERT_CYCLES=4, STAGE_GAP=2,
// TIMEOUT_CYCLES=8) plus a single-stage instance. Builds with or without
// RST_SEQ_ACK_EN.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int N = 3;
  localparam int A = 4;
  localparam int G = 2;
  localparam int T = 8;
`ifdef RST_SEQ_ACK_EN
  localparam int DONE_LAG = 1;  // done waits for last ack, sampled one edge after release
`else
  localparam int DONE_LAG = 0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, sw_rst;
  logic [N-1:0] o_rst;
  logic         done;
  state_t       dbg;
  logic         rst1, sw_rst1;
  logic [0:0]   o_rst1;
  logic         done1;
  state_t       dbg1;
`ifdef RST_SEQ_ACK_EN
  logic [N-1:0] ack;
  logic         err;
  logic [0:0]   ack1;
  logic         err1;
`endif

  int checks   = 0;
  int failures = 0;
  logic [N:0] exp_q[$];  // {done, o_rst}

  reset_sequencer #(.N_STAGES(N), .ASSERT_CYCLES(A), .STAGE_GAP(G), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst(rst), .i_sw_rst(sw_rst), .o_rst(o_rst), .o_dbg_state(dbg),
`ifdef RST_SEQ_ACK_EN
    .i_ack(ack), .o_err(err),
`endif
    .o_done(done)
  );

  reset_sequencer #(.N_STAGES(1), .ASSERT_CYCLES(1), .STAGE_GAP(1), .TIMEOUT_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_sw_rst(sw_rst1), .o_rst(o_rst1), .o_dbg_state(dbg1),
`ifdef RST_SEQ_ACK_EN
    .i_ack(ack1), .o_err(err1),
`endif
    .o_done(done1)
  );

  // ---------------- reference model ----------------
  // e = number of edges that sampled rst_any=0 since the last reset edge.
  // Stage i is released once e reaches A + i*G.
  function automatic logic [N-1:0] exp_rst(input int e);
    logic [N-1:0] r;
    r = '1;
    for (int i = 0; i < N; i++) if (e >= A + i * G) r[i] = 1'b0;
    return r;
  endfunction

  function automatic logic exp_done(input int e);
    return (e >= A + (N - 1) * G + DONE_LAG);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_and_check(input string name, input int first_e, input int last_e);
    for (int e = first_e; e <= last_e; e++) begin
      tick();
      checks++;
      if (o_rst !== exp_rst(e)) begin
        failures++;
        $display("FAIL %s e=%0d o_rst=%b expected=%b", name, e, o_rst, exp_rst(e));
      end
      checks++;
      if (done !== exp_done(e)) begin
        failures++;
        $display("FAIL %s_done e=%0d o_done=%b expected=%b", name, e, done, exp_done(e));
      end
    end
  endtask

  task automatic expect_asserted(input string name);
    checks++;
    if (o_rst !== 3'b111) begin
      failures++;
      $display("FAIL %s o_rst=%b expected=111", name, o_rst);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done o_done=%b expected=0", name, done);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    sw_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_asserted("reset_hold");
    end
    rst = 1'b0;
    run_and_check("reset_release", 1, 10);
  endtask

  task automatic test_sw_rst();
    sw_rst = 1'b1;
    tick();
    expect_asserted("sw_rst_pulse");
    sw_rst = 1'b0;
    run_and_check("sw_rst_release", 1, 10);
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_and_check("mid_pre", 1, 5);
    rst = 1'b1;
    tick();
    expect_asserted("mid_pulse");
    rst = 1'b0;
    run_and_check("mid_restart", 1, 10);
  endtask

  task automatic test_single_stage();
    rst1 = 1'b1;
    tick();
    tick();
    checks++;
    if (o_rst1 !== 1'b1 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL single_reset o_rst=%b o_done=%b expected=1/0", o_rst1, done1);
    end
    rst1 = 1'b0;
    tick();
    checks++;
    if (o_rst1 !== 1'b0) begin
      failures++;
      $display("FAIL single_release o_rst=%b expected=0", o_rst1);
    end
    checks++;
    if (done1 !== (DONE_LAG == 0)) begin
      failures++;
      $display("FAIL single_done_e1 o_done=%b expected=%b", done1, (DONE_LAG == 0));
    end
    tick();
    checks++;
    if (done1 !== 1'b1 || o_rst1 !== 1'b0) begin
      failures++;
      $display("FAIL single_done_e2 o_done=%b o_rst=%b expected=1/0", done1, o_rst1);
    end
  endtask

  task automatic test_random();
    int e;
    logic [N:0] got, want;
    rst = 1'b1;
    sw_rst = 1'b0;
    tick();
    e = 0;
    for (int c = 0; c < 400; c++) begin
      rst    = ($urandom_range(0, 29) == 0);
      sw_rst = ($urandom_range(0, 29) == 0);
      if (rst || sw_rst) e = 0;
      else e = e + 1;
      exp_q.push_back({exp_done(e), exp_rst(e)});
      tick();
      want = exp_q.pop_front();
      got  = {done, o_rst};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL random c=%0d {done,o_rst}=%b expected=%b", c, got, want);
      end
    end
    rst = 1'b0;
    sw_rst = 1'b0;
  endtask

`ifdef RST_SEQ_ACK_EN
  task automatic test_ack_late();
    ack = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) tick();
    checks++;
    if (o_rst !== 3'b110) begin
      failures++;
      $display("FAIL ack_late_wait o_rst=%b expected=110", o_rst);
    end
    ack = 3'b001;
    tick();
    checks++;
    if (o_rst !== 3'b100) begin
      failures++;
      $display("FAIL ack_late_release o_rst=%b expected=100", o_rst);
    end
    ack = 3'b011;
    tick();
    tick();
    checks++;
    if (o_rst !== 3'b000 || done !== 1'b0) begin
      failures++;
      $display("FAIL ack_late_last o_rst=%b o_done=%b expected=000/0", o_rst, done);
    end
    ack = 3'b111;
    tick();
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL ack_late_done o_done=%b o_err=%b expected=1/0", done, err);
    end
  endtask

  task automatic test_ack_timeout();
    ack = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 11; e++) tick();
    checks++;
    if (o_rst !== 3'b110 || err !== 1'b0) begin
      failures++;
      $display("FAIL ack_to_wait o_rst=%b o_err=%b expected=110/0", o_rst, err);
    end
    tick();
    checks++;
    if (o_rst !== 3'b100 || err !== 1'b1) begin
      failures++;
      $display("FAIL ack_to_release o_rst=%b o_err=%b expected=100/1", o_rst, err);
    end
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    checks++;
    if (err !== 1'b1 || o_rst !== 3'b111) begin
      failures++;
      $display("FAIL ack_to_sw_hold o_err=%b o_rst=%b expected=1/111", err, o_rst);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL ack_to_clear o_err=%b expected=0", err);
    end
    ack = '1;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    sw_rst = 1'b0;
    rst1 = 1'b1;
    sw_rst1 = 1'b0;
`ifdef RST_SEQ_ACK_EN
    ack = '1;
    ack1 = 1'b1;
`endif
    test_reset();
    test_sw_rst();
    test_mid_reset();
    test_single_stage();
`ifdef RST_SEQ_ACK_EN
    test_ack_late();
    test_ack_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the already-synchronized, active-high reset from the reset synchronizer stage.
- Produces N_STAGES per-domain reset outputs that assert together and release one at a time, in index order, with programmable spacing.
- Gives dependent blocks (clocking, memories, datapath, host interface) a deterministic release order and a single "system out of reset" indication.

Parameters:
N_STAGES, 4, number of sequenced reset outputs; >= 1
ASSERT_CYCLES, 16, consecutive cycles with i_rst/i_sw_rst low before stage 0 releases; >= 1
STAGE_GAP, 8, cycles between release of stage k-1 and stage k; >= 1
TIMEOUT_CYCLES, 1024, ack wait limit per stage (used only with RST_SEQ_ACK_EN); >= STAGE_GAP

Ports:
i_clk  input  1  clock, the single clock domain
i_rst  input  1  synchronous, active-high reset (output of the synchronizer stage)
i_sw_rst  input  1  synchronous, active-high software reset request; level or pulse
o_rst  output  N_STAGES  per-stage active-high reset; bit 0 releases first
o_done  output  1  high once every stage is released
i_ack  input  N_STAGES  per-stage "init complete" acknowledge (present only with RST_SEQ_ACK_EN)
o_err  output  1  sticky ack-timeout flag (present only with RST_SEQ_ACK_EN)

Behaviour:
- Reset sources:
  - Reset is synchronous and active-high; sampled only on posedge i_clk. No asynchronous paths.
  - rst_any = i_rst | i_sw_rst. Both sources behave identically.
- Reset values (any edge with rst_any=1): o_rst = all ones, o_done = 0, counter = 0, state = S_ASSERT. o_err holds its value on i_sw_rst and clears only on i_rst.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: S_ASSERT, S_RELEASE, S_DONE.
- S_ASSERT:
  - Counter increments on each edge with rst_any=0.
  - On the edge where counter == ASSERT_CYCLES-1: clear o_rst[0], load counter=0, stage index k=1, go to S_RELEASE.
  - If N_STAGES == 1: instead go to S_DONE and set o_done on that same edge.
- S_RELEASE:
  - Counter increments each edge.
  - On the edge where counter == STAGE_GAP-1: clear o_rst[k], reset counter.
  - If k == N_STAGES-1: set o_done on that same edge and go to S_DONE. Otherwise k <= k+1.
- S_DONE: holds. o_rst = 0 and o_done = 1 until rst_any.
- Released stages never re-assert except through rst_any.
- Reset mid-sequence: one edge with rst_any=1 re-asserts every o_rst bit, clears o_done and restarts from S_ASSERT with counter 0. Partial progress is discarded.
- Glitch-length reset: a single-cycle rst_any still restarts the full ASSERT_CYCLES count.
- Widths:
  - Counter width = $clog2(max(ASSERT_CYCLES, STAGE_GAP, TIMEOUT_CYCLES)+1).
  - Stage index width = max(1, $clog2(N_STAGES)).
  - Counter saturates and never wraps.
- Total release latency with ack disabled: ASSERT_CYCLES + (N_STAGES-1)*STAGE_GAP edges after the first edge that samples rst_any=0.

Optional Feature:
RST_SEQ_ACK_EN
- Defined:
  - i_ack and o_err ports exist.
  - Stage k+1 releases only when both conditions hold: STAGE_GAP has elapsed since stage k released, and i_ack[k] is sampled high. The release occurs on the later of the two.
  - If i_ack[k] is still low TIMEOUT_CYCLES edges after stage k released: set o_err (sticky) and release stage k+1 anyway.
  - o_done requires i_ack[N_STAGES-1] or its timeout, so it may lag the last release.
  - i_ack bits for stages that are still in reset are ignored.
- Undefined: ports absent; pure timed sequencing as described in Behaviour.

Decomposition:
- Package reset_seq_pkg:
  - state enum typedef (S_ASSERT, S_RELEASE, S_DONE).
  - constant function for counter width.
  - default parameter constants.
- Sub-module reset_seq_timer: saturating up-counter with synchronous clear and a terminal-count compare input. It is instantiated once and shared between the assert, gap and timeout phases.

Test Plan (N_STAGES=3, ASSERT_CYCLES=4, STAGE_GAP=2, TIMEOUT_CYCLES=8 unless noted; edge 1 = first edge sampling rst_any=0):
- i_rst high 5 cycles, then low -> o_rst=3'b111, o_done=0 during reset; o_rst=3'b110 after edge 4, 3'b100 after edge 6, 3'b000 with o_done=1 after edge 8.
- Sequence complete, then 1-cycle i_sw_rst pulse -> o_rst=3'b111, o_done=0 next edge; the same 4/6/8 release timing repeats relative to the pulse's falling edge.
- i_rst pulsed high for 1 cycle after edge 5 (o_rst=3'b110) -> all bits re-assert, and o_rst[0] releases only 4 edges later.
- N_STAGES=1, ASSERT_CYCLES=1 -> o_rst=0 and o_done=1 after edge 1.
- RST_SEQ_ACK_EN, i_ack[0] raised 5 cycles after o_rst[0] releases -> o_rst[1] releases on the edge sampling i_ack[0]=1, not at the gap; o_err stays 0.
- RST_SEQ_ACK_EN, i_ack held 0 -> o_rst[1] releases 8 edges after o_rst[0]; o_err=1 and stays 1 through i_sw_rst; cleared only by i_rst.
